// File: rtl/ofdm_tx_frame_ctrl.sv
// ofdm_tx_frame_ctrl: config capture, SIGNAL field generation and serial DATA-field bit stream for the OFDM transmitter
module ofdm_tx_frame_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] mcu_config_din,
  input  logic        mcu_config_din_start,
  input  logic        mcu_config_din_vld,
  output logic        mcu_config_dout_rdy,
  input  logic [7:0]  mcu_mac_din,
  input  logic        mcu_mac_din_vld,
  output logic        mcu_mac_dout_rdy,
  output logic [23:0] sig_dout,
  output logic        sig_vld,
  output logic        bit_dout,
  output logic        bit_dout_vld,
  input  logic        bit_din_rdy,
  output logic        bit_dout_last,
  output logic [2:0]  TxPWR,
  output logic        cfg_err,
  output logic        tx_end
);
  typedef enum logic [2:0] {IDLE, WAIT_CFG, SIGNAL, SERVICE, PSDU, TAIL, PAD, DONE} state_t;
  state_t state_q, state_d;
  logic cfg_rdy_q, cfg_rdy_d, mac_rdy_q, mac_rdy_d, sig_vld_q, sig_vld_d;
  logic bit_q, bit_d, bit_vld_q, bit_vld_d, bit_last_q, bit_last_d;
  logic cfg_err_q, cfg_err_d, tx_end_q, tx_end_d, hold_full_q, hold_full_d;
  logic [23:0] sig_q, sig_d;
  logic [2:0] pwr_q, pwr_d;
  logic [11:0] len_q, len_d, bytes_q, bytes_d;
  logic [7:0] ndbps_q, ndbps_d, hold_q, hold_d, sh_q, sh_d, sym_q, sym_d;
  logic [3:0] sh_cnt_q, sh_cnt_d, cnt_q, cnt_d;
  logic [11:0] cfg_len;
  logic rate_ok;
  logic [3:0] rc;
  logic [7:0] nd, sym_n;
  logic xfer, byte_xfer, need;
  assign cfg_len = mcu_config_din[20:9];
  assign xfer = bit_vld_q & bit_din_rdy;
  assign byte_xfer = mcu_mac_din_vld & mac_rdy_q;
  assign need = ~bit_vld_q | xfer;
  assign sym_n = (sym_q == ndbps_q - 8'd1) ? 8'd0 : sym_q + 8'd1;
  always_comb begin
    rate_ok = 1'b1;
    rc = 4'b1101;
    nd = 8'd24;
    case (mcu_config_din[8:3])
      6'd6: begin rc = 4'b1101; nd = 8'd24; end
      6'd9: begin rc = 4'b1111; nd = 8'd36; end
      6'd12: begin rc = 4'b0101; nd = 8'd48; end
      6'd18: begin rc = 4'b0111; nd = 8'd72; end
      6'd24: begin rc = 4'b1001; nd = 8'd96; end
      6'd36: begin rc = 4'b1011; nd = 8'd144; end
      6'd48: begin rc = 4'b0001; nd = 8'd192; end
      6'd54: begin rc = 4'b0011; nd = 8'd216; end
      default: rate_ok = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    sig_d = sig_q;
    sig_vld_d = 1'b0;
    bit_d = bit_q;
    bit_vld_d = bit_vld_q;
    bit_last_d = bit_last_q;
    pwr_d = pwr_q;
    cfg_err_d = 1'b0;
    len_d = len_q;
    ndbps_d = ndbps_q;
    bytes_d = bytes_q;
    hold_d = hold_q;
    hold_full_d = hold_full_q;
    sh_d = sh_q;
    sh_cnt_d = sh_cnt_q;
    cnt_d = cnt_q;
    sym_d = xfer ? sym_n : sym_q;
    if (byte_xfer) begin
      hold_d = mcu_mac_din;
      hold_full_d = 1'b1;
      bytes_d = bytes_q + 12'd1;
    end
    case (state_q)
      IDLE: state_d = mcu_config_din_start ? WAIT_CFG : IDLE;
      WAIT_CFG: if (mcu_config_din_vld) begin
        if (rate_ok && cfg_len != 12'd0) begin
          state_d = SIGNAL;
          sig_vld_d = 1'b1;
          sig_d = {6'd0, ^{cfg_len, rc}, cfg_len, 1'b0, rc[0], rc[1], rc[2], rc[3]};
          pwr_d = mcu_config_din[2:0];
          len_d = cfg_len;
          ndbps_d = nd;
        end else begin
          state_d = IDLE;
          cfg_err_d = 1'b1;
        end
      end
      SIGNAL: begin
        state_d = SERVICE;
        bit_d = 1'b0;
        bit_vld_d = 1'b1;
        bit_last_d = 1'b0;
        cnt_d = 4'd0;
        sym_d = 8'd0;
        bytes_d = 12'd0;
        hold_full_d = 1'b0;
        sh_cnt_d = 4'd0;
      end
      SERVICE: if (xfer) begin
        state_d = (cnt_q == 4'd15) ? PSDU : SERVICE;
        bit_vld_d = cnt_q != 4'd15;
        cnt_d = cnt_q + 4'd1;
      end
      PSDU: if (need) begin
        if (sh_cnt_q != 4'd0) begin
          bit_d = sh_q[0];
          bit_vld_d = 1'b1;
          sh_d = sh_q >> 1;
          sh_cnt_d = sh_cnt_q - 4'd1;
        end else if (hold_full_q) begin
          bit_d = hold_q[0];
          bit_vld_d = 1'b1;
          sh_d = {1'b0, hold_q[7:1]};
          sh_cnt_d = 4'd7;
          hold_full_d = 1'b0;
        end else if (bytes_q == len_q) begin
          state_d = TAIL;
          bit_d = 1'b0;
          bit_vld_d = 1'b1;
          bit_last_d = 1'b0;
          cnt_d = 4'd0;
        end else
          bit_vld_d = 1'b0;
      end
      TAIL: if (xfer) begin
        state_d = bit_last_q ? DONE : (cnt_q == 4'd5) ? PAD : TAIL;
        bit_vld_d = ~bit_last_q;
        bit_last_d = ~bit_last_q & (cnt_q >= 4'd4) & (sym_d == ndbps_q - 8'd1);
        cnt_d = cnt_q + 4'd1;
      end
      PAD: if (xfer) begin
        state_d = bit_last_q ? DONE : PAD;
        bit_vld_d = ~bit_last_q;
        bit_last_d = ~bit_last_q & (sym_d == ndbps_q - 8'd1);
      end
      DONE: state_d = IDLE;
    endcase
    tx_end_d = state_d == DONE;
    cfg_rdy_d = state_d == IDLE;
    mac_rdy_d = (state_d == PSDU) & ~hold_full_d & (bytes_d != len_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_rdy_q <= 1'b0;
      mac_rdy_q <= 1'b0;
      sig_q <= 24'd0;
      sig_vld_q <= 1'b0;
      bit_q <= 1'b0;
      bit_vld_q <= 1'b0;
      bit_last_q <= 1'b0;
      pwr_q <= 3'd0;
      cfg_err_q <= 1'b0;
      tx_end_q <= 1'b0;
      len_q <= 12'd0;
      ndbps_q <= 8'd0;
      bytes_q <= 12'd0;
      hold_q <= 8'd0;
      hold_full_q <= 1'b0;
      sh_q <= 8'd0;
      sh_cnt_q <= 4'd0;
      cnt_q <= 4'd0;
      sym_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cfg_rdy_q <= cfg_rdy_d;
      mac_rdy_q <= mac_rdy_d;
      sig_q <= sig_d;
      sig_vld_q <= sig_vld_d;
      bit_q <= bit_d;
      bit_vld_q <= bit_vld_d;
      bit_last_q <= bit_last_d;
      pwr_q <= pwr_d;
      cfg_err_q <= cfg_err_d;
      tx_end_q <= tx_end_d;
      len_q <= len_d;
      ndbps_q <= ndbps_d;
      bytes_q <= bytes_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q <= sh_d;
      sh_cnt_q <= sh_cnt_d;
      cnt_q <= cnt_d;
      sym_q <= sym_d;
    end
  end
  assign mcu_config_dout_rdy = cfg_rdy_q;
  assign mcu_mac_dout_rdy = mac_rdy_q;
  assign sig_dout = sig_q;
  assign sig_vld = sig_vld_q;
  assign bit_dout = bit_q;
  assign bit_dout_vld = bit_vld_q;
  assign bit_dout_last = bit_last_q;
  assign TxPWR = pwr_q;
  assign cfg_err = cfg_err_q;
  assign tx_end = tx_end_q;
endmodule

// File: tb/tb_ofdm_tx_frame_ctrl.sv
// tb_ofdm_tx_frame_ctrl: scoreboard bench for ofdm_tx_frame_ctrl against a frame-level reference model
module tb_ofdm_tx_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [20:0] mcu_config_din = '0;
  logic mcu_config_din_start = 1'b0;
  logic mcu_config_din_vld = 1'b0;
  logic mcu_config_dout_rdy;
  logic [7:0] mcu_mac_din = '0;
  logic mcu_mac_din_vld = 1'b0;
  logic mcu_mac_dout_rdy;
  logic [23:0] sig_dout;
  logic sig_vld;
  logic bit_dout;
  logic bit_dout_vld;
  logic bit_din_rdy = 1'b1;
  logic bit_dout_last;
  logic [2:0] TxPWR;
  logic cfg_err;
  logic tx_end;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] pl[$];
  logic [1:0] exp_bits[$];
  logic [26:0] exp_sig[$];
  int exp_err = 0;
  bit stall = 1'b0;
  logic [2:0] last_pwr = 3'd0;
  bit prev_last = 1'b0;
  int rates[8] = '{6, 9, 12, 18, 24, 36, 48, 54};
  ofdm_tx_frame_ctrl dut (
    .clk(clk), .rst(rst),
    .mcu_config_din(mcu_config_din), .mcu_config_din_start(mcu_config_din_start),
    .mcu_config_din_vld(mcu_config_din_vld), .mcu_config_dout_rdy(mcu_config_dout_rdy),
    .mcu_mac_din(mcu_mac_din), .mcu_mac_din_vld(mcu_mac_din_vld), .mcu_mac_dout_rdy(mcu_mac_dout_rdy),
    .sig_dout(sig_dout), .sig_vld(sig_vld),
    .bit_dout(bit_dout), .bit_dout_vld(bit_dout_vld), .bit_din_rdy(bit_din_rdy),
    .bit_dout_last(bit_dout_last), .TxPWR(TxPWR), .cfg_err(cfg_err), .tx_end(tx_end)
  );
  initial forever #5 clk = ~clk;
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  function automatic int ndbps(input int r);
    case (r)
      6: return 24;
      9: return 36;
      12: return 48;
      18: return 72;
      24: return 96;
      36: return 144;
      48: return 192;
      54: return 216;
      default: return 1;
    endcase
  endfunction
  // R1..R4 placed in SIGNAL bits 0..3
  function automatic int code(input int r);
    case (r)
      6: return 'hB;
      9: return 'hF;
      12: return 'hA;
      18: return 'hE;
      24: return 'h9;
      36: return 'hD;
      48: return 'h8;
      54: return 'hC;
      default: return 0;
    endcase
  endfunction
  task automatic model(input int len, input int rate, input int pwr, input int sig_lit);
    int n, tot;
    logic [23:0] s;
    logic [7:0] by;
    logic b;
    n = ndbps(rate);
    tot = ((22 + 8 * len + n - 1) / n) * n;
    s = 24'(code(rate) + len * 32);
    s[17] = ($countones(s[16:0]) % 2) != 0;
    if (sig_lit >= 0) s = sig_lit[23:0];
    exp_sig.push_back({3'(pwr), s});
    for (int i = 0; i < tot; i++) begin
      b = 1'b0;
      if (i >= 16 && i < 16 + 8 * len) begin
        by = pl[(i - 16) / 8];
        b = by[(i - 16) % 8];
      end
      exp_bits.push_back({b, i == tot - 1});
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    bit_din_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial forever begin
    logic [26:0] es;
    logic [1:0] eb;
    @(negedge clk);
    if (rst) begin
      prev_last = 1'b0;
      continue;
    end
    if (sig_vld) begin
      chk("sig_expected", exp_sig.size() != 0, 1);
      if (exp_sig.size() != 0) begin
        es = exp_sig.pop_front();
        chk("sig_pwr", {TxPWR, sig_dout}, es);
      end
    end
    if (bit_dout_vld && bit_din_rdy) begin
      chk("bit_expected", exp_bits.size() != 0, 1);
      if (exp_bits.size() != 0) begin
        eb = exp_bits.pop_front();
        chk("bit_last", {bit_dout, bit_dout_last}, eb);
      end
    end
    if (cfg_err) begin
      chk("cfg_err_expected", exp_err > 0, 1);
      if (exp_err > 0) exp_err--;
    end
    if (tx_end || prev_last) chk("tx_end_timing", tx_end, prev_last);
    prev_last = bit_dout_vld & bit_din_rdy & bit_dout_last;
  end
  task automatic wait_cfg_rdy();
    int t = 0;
    while (!mcu_config_dout_rdy && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("cfg_rdy", mcu_config_dout_rdy, 1);
  endtask
  task automatic send_cfg(input logic [20:0] w);
    mcu_config_din_start = 1'b1;
    @(posedge clk);
    #1;
    mcu_config_din_start = 1'b0;
    mcu_config_din_vld = 1'b1;
    mcu_config_din = w;
    @(posedge clk);
    #1;
    mcu_config_din_vld = 1'b0;
  endtask
  task automatic frame(input int len, input int rate, input int pwr, input int sig_lit, input int mode, input bit gaps, input int abort_at);
    bit ok;
    int t;
    pl.delete();
    for (int k = 0; k < len; k++) pl.push_back(mode == 0 ? 8'(k) : mode == 1 ? 8'($urandom) : 8'hA5);
    model(len, rate, pwr, sig_lit);
    wait_cfg_rdy();
    send_cfg({12'(len), 6'(rate), 3'(pwr)});
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) return;
      if (gaps) repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      mcu_mac_din = pl[k];
      mcu_mac_din_vld = 1'b1;
      ok = 1'b0;
      t = 0;
      while (!ok && t < 400) begin
        @(negedge clk);
        ok = mcu_mac_dout_rdy;
        @(posedge clk);
        #1;
        t++;
      end
      mcu_mac_din_vld = 1'b0;
      chk("byte_accept", ok, 1);
    end
    ok = 1'b0;
    t = 0;
    while (!ok && t < 6000) begin
      @(negedge clk);
      ok = tx_end;
      @(posedge clk);
      #1;
      t++;
    end
    chk("tx_end_seen", ok, 1);
    chk("bits_left", exp_bits.size(), 0);
    last_pwr = 3'(pwr);
  endtask
  task automatic bad(input int len, input int rate);
    wait_cfg_rdy();
    exp_err++;
    send_cfg({12'(len), 6'(rate), 3'd7});
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("cfg_err_pulse", exp_err, 0);
    chk("rdy_after_err", mcu_config_dout_rdy, 1);
    chk("pwr_kept", TxPWR, last_pwr);
  endtask
  task automatic check_reset_outputs();
    @(negedge clk);
    chk("reset_outputs", {mcu_config_dout_rdy, mcu_mac_dout_rdy, sig_dout, sig_vld, bit_dout,
                          bit_dout_vld, bit_dout_last, TxPWR, cfg_err, tx_end}, 0);
  endtask
  initial begin
    int r;
    repeat (5) @(posedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rdy_after_reset", mcu_config_dout_rdy, 1);
    frame(90, 36, 0, 'h20B4D, 0, 1'b0, -1);
    frame(1, 6, 5, 'h00002B, 2, 1'b0, -1);
    bad(10, 7);
    bad(0, 6);
    stall = 1'b1;
    frame(90, 36, 2, -1, 0, 1'b1, -1);
    for (int i = 0; i < 6; i++) begin
      r = rates[$urandom_range(0, 7)];
      stall = 1'($urandom_range(0, 1));
      frame(int'($urandom_range(1, 40)), r, int'($urandom_range(0, 7)), -1, 1, 1'($urandom_range(0, 1)), -1);
    end
    stall = 1'b1;
    frame(20, 12, 3, -1, 1, 1'b1, 5);
    rst = 1'b1;
    mcu_mac_din_vld = 1'b0;
    @(posedge clk);
    #1;
    exp_bits.delete();
    exp_sig.delete();
    check_reset_outputs();
    rst = 1'b0;
    last_pwr = 3'd0;
    @(posedge clk);
    #1;
    chk("rdy_after_midreset", mcu_config_dout_rdy, 1);
    frame(30, 54, 6, -1, 1, 1'b1, -1);
    stall = 1'b0;
    frame(12, 9, 1, -1, 1, 1'b0, -1);
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ofdm_tx_frame_ctrl.md
# ofdm_tx_frame_ctrl

Single-clock MCU-facing front end of the OFDM transmitter, instantiated ahead of the scrambler/encoder chain inside the transmit wrapper. It accepts a 21-bit frame configuration word and the PSDU byte stream over valid/ready handshakes. It emits the 24-bit 802.11a SIGNAL field and a serial DATA-field bit stream: SERVICE, PSDU LSB-first, tail, then pad up to a whole OFDM symbol.

## Interface
- Parameters: none; all field widths are fixed.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- mcu_config_din  in  21  config word: [20:9] LENGTH in bytes, [8:3] RATE in Mbps, [2:0] TX_PWR.
- mcu_config_din_start  in  1  frame-start strobe.
- mcu_config_din_vld  in  1  config word valid.
- mcu_config_dout_rdy  out  1  block idle; a new frame may start.
- mcu_mac_din  in  8  PSDU byte.
- mcu_mac_din_vld  in  1  byte valid.
- mcu_mac_dout_rdy  out  1  block will accept a byte.
- sig_dout  out  24  SIGNAL field; bit i is the i-th transmitted bit.
- sig_vld  out  1  one-cycle strobe qualifying sig_dout.
- bit_dout  out  1  DATA-field bit.
- bit_dout_vld  out  1  bit valid.
- bit_din_rdy  in  1  downstream ready.
- bit_dout_last  out  1  marks the final pad bit.
- TxPWR  out  3  TX_PWR latched from the config word.
- cfg_err  out  1  one-cycle pulse when a config word is rejected.
- tx_end  out  1  one-cycle pulse when the frame is complete.

## Operation
- FSM states: IDLE, WAIT_CFG, SIGNAL, SERVICE, PSDU, TAIL, PAD, DONE.
- IDLE: mcu_config_dout_rdy=1. A cycle with start=1 moves the FSM to WAIT_CFG.
- WAIT_CFG: rdy=0. A cycle with vld=1 captures the word.
- Config validation:
  - Valid RATE values are 6, 9, 12, 18, 24, 36, 48, 54.
  - LENGTH must be nonzero.
  - Valid word: go to SIGNAL.
  - Invalid word: pulse cfg_err and return to IDLE; TxPWR is left unchanged.
- RATE lookup (Mbps -> rate code R1..R4, N_DBPS):
  - 6 -> 1101, 24
  - 9 -> 1111, 36
  - 12 -> 0101, 48
  - 18 -> 0111, 72
  - 24 -> 1001, 96
  - 36 -> 1011, 144
  - 48 -> 0001, 192
  - 54 -> 0011, 216
- SIGNAL field layout:
  - bits 0-3 = R1..R4
  - bit 4 = 0
  - bits 5-16 = LENGTH, LSB first
  - bit 17 = even parity over bits 0-16
  - bits 18-23 = 0
- SIGNAL state: sig_vld=1 for exactly one cycle, then SERVICE.
- SERVICE: emits 16 zero bits.
- PSDU state:
  - Exactly LENGTH bytes are accepted; each is emitted bit 0 first.
  - A one-byte holding register plus an 8-bit shifter are used.
  - mcu_mac_dout_rdy=1 only in PSDU, with the holding register empty and bytes accepted < LENGTH.
  - Bits are emitted only when the shifter is non-empty.
- TAIL: emits 6 zero bits.
- PAD: emits zero bits until the total DATA bit count is a multiple of N_DBPS.
  - A per-symbol counter runs 0..N_DBPS-1 across all DATA bits.
  - If the counter is already 0 after the tail, PAD emits no bits.
- bit_dout_last is asserted on the final DATA bit, whether that bit is a pad or a tail bit.
- DONE: tx_end=1 for one cycle, then IDLE.
- Total DATA bits = N_DBPS * ceil((22 + 8*LENGTH) / N_DBPS).

## Timing
- Reset values, all outputs: rdy outputs 0, sig_dout 0, sig_vld 0, bit_dout 0, bit_dout_vld 0, bit_dout_last 0, TxPWR 0, cfg_err 0, tx_end 0.
- mcu_config_dout_rdy goes to 1 on the first cycle after rst deasserts.
- All outputs are registered.
- Capture timing:
  - start sampled in IDLE -> WAIT_CFG on the next cycle.
  - vld sampled in WAIT_CFG -> sig_vld on the next cycle.
  - SERVICE begins the cycle after sig_vld.
- A bit transfers on each cycle where bit_dout_vld & bit_din_rdy.
  - bit_dout and bit_dout_vld hold while bit_din_rdy=0.
  - bit_dout_vld is constantly 1 in SERVICE, TAIL and PAD.
- A byte transfers on each cycle where mcu_mac_din_vld & mcu_mac_dout_rdy.
  - A byte accepted while the shifter is busy is loaded into the shifter in the cycle its last bit transfers, so back-to-back bytes cause no bubble.
- tx_end pulses the cycle after the bit_dout_last transfer.
- Inputs arriving in the wrong state are ignored: vld outside WAIT_CFG, start outside IDLE, MAC bytes outside PSDU.
- rst mid-frame returns the FSM to IDLE with reset values on the next edge; partial-frame state is discarded.

## Test plan
- Reset: hold rst for 5 cycles, then release -> all outputs 0 during reset; mcu_config_dout_rdy=1 one cycle after release.
- LENGTH=90, RATE=36, PWR=0, bytes from a counter source:
  - sig_dout=0x20B4D and TxPWR=0.
  - 864 bit transfers: 16 zeros, then 720 PSDU bits LSB-first, then 6+122 zeros.
  - bit_dout_last on transfer 864; tx_end one cycle later.
- LENGTH=1, RATE=6, byte 0xA5 -> sig_dout=0x00002B; 48 DATA bits; bits 16-23 = 1,0,1,0,0,1,0,1.
- Invalid config, RATE=7 or LENGTH=0 -> cfg_err single pulse; no sig_vld; back in IDLE with rdy=1.
- Backpressure: bit_din_rdy toggled randomly and mcu_mac_din_vld gapped -> bit sequence identical to the no-stall case; no byte lost or duplicated.
- rst asserted mid-PSDU, then a new frame issued -> clean restart; second frame fully correct.
